// File: rtl/just_pass_reg_if.sv
// Bus bundle for the registered pass-through stage: input word, delayed word and fill flag.
interface just_pass_reg_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  bool_o;

    // No valid/ready: data_i is accepted on every rising edge outside reset,
    // and data_o is qualified by bool_o, which the sink may ignore.
    modport master (output data_i, input data_o, input bool_o);
    modport slave  (input data_i, output data_o, output bool_o);
endinterface

// File: rtl/just_pass_reg.sv
// Fixed-latency registered pass-through; a valid bit travels alongside each word so
// bool_o separates real data from reset fill.
module just_pass_reg #(
    parameter int DATA_WIDTH = 8,
    parameter int LATENCY    = 1
) (
    input  logic           clk,
    input  logic           rstn,
    just_pass_reg_if.slave bus
);
    logic [DATA_WIDTH-1:0] stage_q [LATENCY];
    logic [DATA_WIDTH-1:0] stage_d [LATENCY];
    logic [LATENCY-1:0]    valid_q;
    logic [LATENCY-1:0]    valid_d;

    always_comb begin
        stage_d[0] = bus.data_i;
        valid_d[0] = 1'b1;
        for (int k = 1; k < LATENCY; k++) begin
            stage_d[k] = stage_q[k-1];
            valid_d[k] = valid_q[k-1];
        end
    end

    // rstn is active-high despite its name; reset wins over capture.
    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int k = 0; k < LATENCY; k++) begin
                stage_q[k] <= '0;
            end
            valid_q <= '0;
        end else begin
            stage_q <= stage_d;
            valid_q <= valid_d;
        end
    end

    assign bus.data_o = stage_q[LATENCY-1];
    assign bus.bool_o = valid_q[LATENCY-1];
endmodule

// File: tb/tb_just_pass_reg.sv
// Directed bench for just_pass_reg: a LATENCY=1/8-bit and a LATENCY=4/16-bit instance share clock and reset.
module tb_just_pass_reg;
    logic clk;
    logic rstn;
    int   total;
    int   bad;

    logic [7:0]  exp1_q [$];
    logic [15:0] exp4_q [$];

    just_pass_reg_if #(.DATA_WIDTH(8))  bus1 ();
    just_pass_reg_if #(.DATA_WIDTH(16)) bus4 ();

    just_pass_reg #(.DATA_WIDTH(8), .LATENCY(1)) dut1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1.slave)
    );

    just_pass_reg #(.DATA_WIDTH(16), .LATENCY(4)) dut4 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one edge; the history of accepted words restarts on every reset edge.
    task automatic step(input logic r, input logic [7:0] v1, input logic [15:0] v4);
        rstn        = r;
        bus1.data_i = v1;
        bus4.data_i = v4;
        @(posedge clk);
        #1;
        if (r) begin
            exp1_q.delete();
            exp4_q.delete();
        end else begin
            exp1_q.push_back(v1);
            exp4_q.push_back(v4);
        end
    endtask

    // Expected output is the word accepted LATENCY edges ago, or 0/0 while filling.
    task automatic check_model(input string tag);
        logic [7:0]  e1;
        logic        b1;
        logic [15:0] e4;
        logic        b4;
        if (exp1_q.size() >= 1) begin
            e1 = exp1_q[exp1_q.size()-1];
            b1 = 1'b1;
        end else begin
            e1 = '0;
            b1 = 1'b0;
        end
        if (exp4_q.size() >= 4) begin
            e4 = exp4_q[exp4_q.size()-4];
            b4 = 1'b1;
        end else begin
            e4 = '0;
            b4 = 1'b0;
        end
        chk({tag, ".d1"}, 64'(bus1.data_o), 64'(e1));
        chk({tag, ".b1"}, 64'(bus1.bool_o), 64'(b1));
        chk({tag, ".d4"}, 64'(bus4.data_o), 64'(e4));
        chk({tag, ".b4"}, 64'(bus4.bool_o), 64'(b4));
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rstn        = 1'b1;
        bus1.data_i = '0;
        bus4.data_i = '0;

        // Reset held with random data: outputs stay 0/0.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)));
            chk("rst.d1", 64'(bus1.data_o), 64'h0);
            chk("rst.b1", 64'(bus1.bool_o), 64'h0);
            chk("rst.d4", 64'(bus4.data_o), 64'h0);
            chk("rst.b4", 64'(bus4.bool_o), 64'h0);
        end

        // First words after release; deep pipe counts up from 1.
        step(1'b0, 8'hA5, 16'h0001);
        chk("p1.d1", 64'(bus1.data_o), 64'hA5);
        chk("p1.b1", 64'(bus1.bool_o), 64'h1);
        chk("p1.b4", 64'(bus4.bool_o), 64'h0);
        step(1'b0, 8'h3C, 16'h0002);
        chk("p2.d1", 64'(bus1.data_o), 64'h3C);
        chk("p2.b4", 64'(bus4.bool_o), 64'h0);
        step(1'b0, 8'h00, 16'h0003);
        chk("p3.b4", 64'(bus4.bool_o), 64'h0);
        chk("p3.d4", 64'(bus4.data_o), 64'h0);
        step(1'b0, 8'h00, 16'h0004);
        chk("p4.b4", 64'(bus4.bool_o), 64'h1);
        chk("p4.d4", 64'(bus4.data_o), 64'h0001);
        for (int i = 5; i < 9; i++) begin
            step(1'b0, 8'(i), 16'(i));
            chk("inc.d4", 64'(bus4.data_o), 64'(i - 3));
            chk("inc.b4", 64'(bus4.bool_o), 64'h1);
        end

        // Random stream.
        for (int i = 0; i < 150; i++) begin
            step(1'b0, 8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)));
            check_model("rand");
        end

        // One-edge reset in mid-stream discards in-flight words.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)));
        end
        step(1'b1, 8'hFF, 16'hFFFF);
        chk("mid.d1", 64'(bus1.data_o), 64'h0);
        chk("mid.b1", 64'(bus1.bool_o), 64'h0);
        chk("mid.d4", 64'(bus4.data_o), 64'h0);
        chk("mid.b4", 64'(bus4.bool_o), 64'h0);
        step(1'b0, 8'h11, 16'h0011);
        chk("mid1.d1", 64'(bus1.data_o), 64'h11);
        chk("mid1.b1", 64'(bus1.bool_o), 64'h1);
        step(1'b0, 8'h12, 16'h0012);
        step(1'b0, 8'h13, 16'h0013);
        chk("mid3.b4", 64'(bus4.bool_o), 64'h0);
        step(1'b0, 8'h14, 16'h0014);
        chk("mid4.d4", 64'(bus4.data_o), 64'h0011);
        chk("mid4.b4", 64'(bus4.bool_o), 64'h1);

        // Back-to-back resets: the word between them must never appear.
        step(1'b1, 8'h00, 16'h0000);
        step(1'b0, 8'h22, 16'h2222);
        step(1'b1, 8'h00, 16'h0000);
        check_model("b2b.rst");
        step(1'b0, 8'h33, 16'h3333);
        chk("b2b.d1", 64'(bus1.data_o), 64'h33);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h34, 16'h3434);
            check_model("b2b");
        end
        chk("b2b.d4", 64'(bus4.data_o), 64'h3333);

        // Boundary values alternate every cycle.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, (i % 2 == 0) ? 8'h00 : 8'hFF, (i % 2 == 0) ? 16'h0000 : 16'hFFFF);
            check_model("alt");
        end

        // X on the input is carried through unchanged.
        step(1'b0, 8'hxx, 16'h5A5A);
        chk("x.d1", 64'(bus1.data_o), 64'(8'hxx));

        // Long reset with activity on data_i.
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)));
            check_model("lrst");
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)));
            check_model("refill");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
